// File: rtl/load_store_unit_pkg.sv
// Shared types and constants for the load/store unit and its lane-alignment helper.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    LSU__IDLE   = 2'd0,
    LSU__ACCESS = 2'd1,
    LSU__RESP   = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    LSU_ERR__NONE       = 2'd0,
    LSU_ERR__MISALIGNED = 2'd1,
    LSU_ERR__ILLEGAL    = 2'd2,
    LSU_ERR__TIMEOUT    = 2'd3
  } lsu_err_t;

  // RV32I load/store funct3 encodings
  localparam logic [2:0] FUNCT3__LB  = 3'b000;
  localparam logic [2:0] FUNCT3__LH  = 3'b001;
  localparam logic [2:0] FUNCT3__LW  = 3'b010;
  localparam logic [2:0] FUNCT3__LBU = 3'b100;
  localparam logic [2:0] FUNCT3__LHU = 3'b101;
  localparam logic [2:0] FUNCT3__SB  = 3'b000;
  localparam logic [2:0] FUNCT3__SH  = 3'b001;
  localparam logic [2:0] FUNCT3__SW  = 3'b010;

  // Stores only have sb/sh/sw; loads additionally have the unsigned byte/half forms.
  function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
    logic ok;
    ok = 1'b0;
    if (is_store) begin
      case (funct3)
        FUNCT3__SB, FUNCT3__SH, FUNCT3__SW: ok = 1'b1;
        default:                            ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        FUNCT3__LB, FUNCT3__LH, FUNCT3__LW,
        FUNCT3__LBU, FUNCT3__LHU:           ok = 1'b1;
        default:                            ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_lsu_align.sv
// Combinational byte-lane logic: legality flags, byte enables, store lane
// replication and load lane extraction with sign/zero extension.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        illegal,
  output logic        misaligned
);

  logic [31:0] shifted_s;

  // Legality: unknown widths are illegal; known widths must be naturally aligned.
  always_comb begin
    illegal    = ~funct3_legal(is_store, funct3);
    misaligned = 1'b0;
    if (!illegal) begin
      case (funct3[1:0])
        2'b01:   misaligned = offset[0];
        2'b10:   misaligned = (offset != 2'b00);
        default: misaligned = 1'b0;
      endcase
    end else begin
      misaligned = 1'b0;
    end
  end

  // Byte enables and store data replicated so every lane carries the datum.
  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata;
    case (funct3[1:0])
      2'b00: begin
        be         = 4'b0001 << offset;
        wdata_lane = {4{wdata[7:0]}};
      end
      2'b01: begin
        be         = 4'b0011 << offset;
        wdata_lane = {2{wdata[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        wdata_lane = wdata;
      end
    endcase
  end

  // Load data: move the addressed lane to bit 0, then extend per funct3.
  always_comb begin
    shifted_s = rdata >> {offset, 3'b000};
    rdata_ext = 32'd0;
    case (funct3)
      FUNCT3__LB:  rdata_ext = {{24{shifted_s[7]}}, shifted_s[7:0]};
      FUNCT3__LH:  rdata_ext = {{16{shifted_s[15]}}, shifted_s[15:0]};
      FUNCT3__LW:  rdata_ext = rdata;
      FUNCT3__LBU: rdata_ext = {24'd0, shifted_s[7:0]};
      FUNCT3__LHU: rdata_ext = {16'd0, shifted_s[15:0]};
      default:     rdata_ext = 32'd0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: one request at a time, registered memory strobe
// with wait-state tolerance and timeout, one-cycle response pulse.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  // The counter holds the number of unacked ACCESS cycles already spent.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 32'd1);

  lsu_state_t  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [1:0]  resp_err_q, resp_err_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  offset_q, offset_d;

  logic        sel_store_s;
  logic [2:0]  sel_funct3_s;
  logic [1:0]  sel_offset_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_lane_s;
  logic [31:0] rdata_ext_s;
  logic        illegal_s;
  logic        misaligned_s;

  // In IDLE the aligner looks at the incoming request; afterwards at the latched one.
  always_comb begin
    if (state_q == LSU__IDLE) begin
      sel_store_s  = req_we;
      sel_funct3_s = req_funct3;
      sel_offset_s = req_addr[1:0];
    end else begin
      sel_store_s  = mem_we_q;
      sel_funct3_s = funct3_q;
      sel_offset_s = offset_q;
    end
  end

  lsu_align u_align (
    .is_store   (sel_store_s),
    .funct3     (sel_funct3_s),
    .offset     (sel_offset_s),
    .wdata      (req_wdata),
    .rdata      (mem_rdata),
    .be         (be_s),
    .wdata_lane (wdata_lane_s),
    .rdata_ext  (rdata_ext_s),
    .illegal    (illegal_s),
    .misaligned (misaligned_s)
  );

  // Next-state and next-output computation for the access FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;
    funct3_d     = funct3_q;
    offset_d     = offset_q;
    case (state_q)
      LSU__IDLE: begin
        if (req_valid && req_ready_q) begin
          funct3_d = req_funct3;
          offset_d = req_addr[1:0];
          cnt_d    = 16'd0;
          if (illegal_s) begin
            state_d      = LSU__RESP;
            resp_err_d   = LSU_ERR__ILLEGAL;
            resp_rdata_d = 32'd0;
          end else if (misaligned_s) begin
            state_d      = LSU__RESP;
            resp_err_d   = LSU_ERR__MISALIGNED;
            resp_rdata_d = 32'd0;
          end else begin
            state_d     = LSU__ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_be_d    = be_s;
            mem_wdata_d = req_we ? wdata_lane_s : 32'd0;
          end
        end else begin
          state_d = LSU__IDLE;
        end
      end
      LSU__ACCESS: begin
        // Ack is checked first so a coinciding ack beats the timeout.
        if (mem_ack) begin
          state_d      = LSU__RESP;
          resp_err_d   = LSU_ERR__NONE;
          resp_rdata_d = mem_we_q ? 32'd0 : rdata_ext_s;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d      = LSU__RESP;
          resp_err_d   = LSU_ERR__TIMEOUT;
          resp_rdata_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
        if (state_d == LSU__RESP) begin
          cnt_d       = 16'd0;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = 32'd0;
          mem_be_d    = 4'd0;
          mem_wdata_d = 32'd0;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      LSU__RESP: begin
        state_d = LSU__IDLE;
      end
      default: begin
        state_d = LSU__IDLE;
      end
    endcase
    // Ready and the response pulse are registered views of the upcoming state.
    req_ready_d  = (state_d == LSU__IDLE);
    resp_valid_d = (state_d == LSU__RESP);
  end

  // State and output registers; reset forces everything, including req_ready, low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= LSU__IDLE;
      cnt_q        <= 16'd0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 2'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_be_q     <= 4'd0;
      mem_wdata_q  <= 32'd0;
      funct3_q     <= 3'd0;
      offset_q     <= 2'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
      funct3_q     <= funct3_d;
      offset_q     <= offset_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, randomized
// requests against a behavioural model, and hand-written reset/late-ack sequences.
module tb_load_store_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_dly;   // ack in the (ack_dly+1)-th mem_req cycle; large = never
    logic [31:0] rdata;
    logic [1:0]  exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    int          exp_rc;    // cycles mem_req is high
    int          exp_lat;   // cycles from acceptance to resp_valid
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  vec_t tbl[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input int ack, input logic [31:0] rdata,
                              input logic [1:0] err, input logic [31:0] er, input logic [3:0] be,
                              input logic [31:0] ew, input int rc, input int lat);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.ack_dly = ack; v.rdata = rdata;
    v.exp_err = err; v.exp_rdata = er; v.exp_be = be; v.exp_wdata = ew;
    v.exp_rc = rc; v.exp_lat = lat;
    return v;
  endfunction

  // Behavioural reference: access size, lane arithmetic and extension from first principles.
  function automatic vec_t model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input int ack, input logic [31:0] rdata);
    vec_t v;
    int size, off, b;
    bit legal;
    logic [31:0] val, mask;
    v = mk(we, f3, addr, wdata, ack, rdata, 2'd0, 32'd0, 4'd0, 32'd0, 0, 1);
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
    off   = int'(addr % 32'd4);
    b     = ((1 << size) - 1) << off;
    v.exp_be = b[3:0];
    for (int i = 0; i < 4; i++) v.exp_wdata[8*i +: 8] = wdata[8*(i % size) +: 8];
    val = rdata >> (8 * off);
    if (size < 4) begin
      mask = (32'd1 << (8 * size)) - 32'd1;
      val  = val & mask;
      if (!f3[2] && val[8*size-1]) val = val | ~mask;
    end
    if (!legal) begin
      v.exp_err = 2'd2;
    end else if ((off % size) != 0) begin
      v.exp_err = 2'd1;
    end else if (ack >= TMO) begin
      v.exp_err = 2'd3; v.exp_rc = TMO; v.exp_lat = TMO + 1;
    end else begin
      v.exp_rc = ack + 1; v.exp_lat = ack + 2;
      v.exp_rdata = we ? 32'd0 : val;
    end
    return v;
  endfunction

  // Issue one request and play the memory; returns what the DUT produced.
  task automatic run_req(input vec_t v, output logic [31:0] o_rdata, output logic [1:0] o_err,
                         output int o_lat, output int o_rc, output logic [3:0] o_be,
                         output logic [31:0] o_addr, output logic [31:0] o_wdata,
                         output logic o_we, output logic o_stable);
    int w;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    check("ready_wait", {31'd0, req_ready}, 32'd1);
    o_be = 4'd0; o_addr = 32'd0; o_wdata = 32'd0; o_we = 1'b0;
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    mem_rdata = v.rdata;
    @(negedge clk);
    // Scramble request fields after acceptance: the unit must have latched them.
    req_valid = 1'b0; req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_we = 1'($urandom);
    o_lat = 1; o_rc = 0; o_stable = 1'b1;
    while (!resp_valid && o_lat < 60) begin
      if (mem_req) begin
        if (o_rc == 0) begin
          o_be = mem_be; o_addr = mem_addr; o_wdata = mem_wdata; o_we = mem_we;
        end else if (mem_be !== o_be || mem_addr !== o_addr || mem_wdata !== o_wdata || mem_we !== o_we) begin
          o_stable = 1'b0;
        end
        mem_ack = (o_rc == v.ack_dly);
        o_rc++;
      end else begin
        mem_ack = 1'b0;
      end
      @(negedge clk);
      o_lat++;
    end
    mem_ack = 1'b0;
    o_rdata = resp_rdata;
    o_err   = resp_err;
  endtask

  task automatic apply_and_check(input vec_t v, input string tag);
    logic [31:0] rd, ad, wd;
    logic [1:0]  er;
    logic [3:0]  be;
    logic        we, st;
    int          lat, rc;
    run_req(v, rd, er, lat, rc, be, ad, wd, we, st);
    check($sformatf("%s err", tag), {30'd0, er}, {30'd0, v.exp_err});
    check($sformatf("%s rdata", tag), rd, v.exp_rdata);
    check($sformatf("%s latency", tag), lat, v.exp_lat);
    check($sformatf("%s mem_req_cycles", tag), rc, v.exp_rc);
    if (v.exp_rc > 0) begin
      check($sformatf("%s mem_addr", tag), ad, v.addr & 32'hFFFF_FFFC);
      check($sformatf("%s mem_be", tag), {28'd0, be}, {28'd0, v.exp_be});
      check($sformatf("%s mem_we", tag), {31'd0, we}, {31'd0, v.we});
      check($sformatf("%s stable", tag), {31'd0, st}, 32'd1);
      if (v.we) check($sformatf("%s mem_wdata", tag), wd, v.exp_wdata);
    end
    @(negedge clk);
    check($sformatf("%s pulse_width", tag), {31'd0, resp_valid}, 32'd0);
    check($sformatf("%s rdata_hold", tag), resp_rdata, v.exp_rdata);
  endtask

  initial begin
    vec_t v;
    int hits;

    // Directed vectors (values derived by hand from the access rules).
    tbl[0]  = mk(1'b1, 3'b001, 32'h102, 32'hDEADBEEF, 2, 32'h0, 2'd0, 32'h0, 4'b1100, 32'hBEEFBEEF, 3, 4);
    tbl[1]  = mk(1'b0, 3'b000, 32'h203, 32'h0, 0, 32'h80FF7F01, 2'd0, 32'hFFFFFF80, 4'b1000, 32'h0, 1, 2);
    tbl[2]  = mk(1'b0, 3'b100, 32'h203, 32'h0, 0, 32'h80FF7F01, 2'd0, 32'h00000080, 4'b1000, 32'h0, 1, 2);
    tbl[3]  = mk(1'b0, 3'b000, 32'h201, 32'h0, 0, 32'h80FF7F01, 2'd0, 32'h0000007F, 4'b0010, 32'h0, 1, 2);
    tbl[4]  = mk(1'b0, 3'b000, 32'h202, 32'h0, 0, 32'h80FF7F01, 2'd0, 32'hFFFFFFFF, 4'b0100, 32'h0, 1, 2);
    tbl[5]  = mk(1'b0, 3'b010, 32'h006, 32'h0, 0, 32'h11111111, 2'd1, 32'h0, 4'b0000, 32'h0, 0, 1);
    tbl[6]  = mk(1'b1, 3'b100, 32'h020, 32'h1, 0, 32'h0, 2'd2, 32'h0, 4'b0000, 32'h0, 0, 1);
    tbl[7]  = mk(1'b0, 3'b010, 32'h040, 32'h0, 99, 32'h55555555, 2'd3, 32'h0, 4'b1111, 32'h0, 4, 5);
    tbl[8]  = mk(1'b0, 3'b010, 32'h044, 32'h0, 3, 32'h12345678, 2'd0, 32'h12345678, 4'b1111, 32'h0, 4, 5);
    tbl[9]  = mk(1'b0, 3'b001, 32'h302, 32'h0, 0, 32'hABCD1234, 2'd0, 32'hFFFFABCD, 4'b1100, 32'h0, 1, 2);
    tbl[10] = mk(1'b0, 3'b101, 32'h302, 32'h0, 0, 32'hABCD1234, 2'd0, 32'h0000ABCD, 4'b1100, 32'h0, 1, 2);
    tbl[11] = mk(1'b1, 3'b010, 32'h010, 32'h11223344, 1, 32'h0, 2'd0, 32'h0, 4'b1111, 32'h11223344, 2, 3);
    tbl[12] = mk(1'b1, 3'b000, 32'h013, 32'h000000A5, 0, 32'h0, 2'd0, 32'h0, 4'b1000, 32'hA5A5A5A5, 1, 2);
    tbl[13] = mk(1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 2'd2, 32'h0, 4'b0000, 32'h0, 0, 1);
    tbl[14] = mk(1'b1, 3'b001, 32'h101, 32'h1234, 0, 32'h0, 2'd1, 32'h0, 4'b0000, 32'h0, 0, 1);
    tbl[15] = mk(1'b0, 3'b010, 32'h208, 32'h0, 0, 32'h80FF7F01, 2'd0, 32'h80FF7F01, 4'b1111, 32'h0, 1, 2);

    // Reset state: everything low while reset is asserted.
    #1 reset = 1'b0;
    #1;
    check("rst req_ready", {31'd0, req_ready}, 32'd0);
    check("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst mem_req", {31'd0, mem_req}, 32'd0);
    check("rst mem_we", {31'd0, mem_we}, 32'd0);
    check("rst mem_be", {28'd0, mem_be}, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    check("rst resp_rdata", resp_rdata, 32'd0);
    check("rst resp_err", {30'd0, resp_err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1 check("post_rst ready_low", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("post_rst ready_high", {31'd0, req_ready}, 32'd1);

    // Directed table.
    for (int i = 0; i < 16; i++) apply_and_check(tbl[i], $sformatf("vec%0d", i));

    // Late ack after a timeout must not produce a response or a strobe.
    apply_and_check(tbl[7], "late_ack_pre");
    mem_ack = 1'b1;
    hits = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (resp_valid || mem_req) hits++;
    end
    mem_ack = 1'b0;
    check("late_ack no_response", hits, 0);

    // Randomized requests against the behavioural model.
    for (int i = 0; i < 40; i++) begin
      v = model(1'($urandom), 3'($urandom), $urandom & 32'h0000FFFF, $urandom,
                int'($urandom_range(0, 5)), $urandom);
      apply_and_check(v, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of an access.
    hits = 0;
    while (!req_ready && hits < 20) begin @(negedge clk); hits++; end
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h80;
    @(negedge clk);
    req_valid = 1'b0;
    check("midrst in_access", {31'd0, mem_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("midrst mem_req", {31'd0, mem_req}, 32'd0);
    check("midrst mem_be", {28'd0, mem_be}, 32'd0);
    check("midrst mem_addr", mem_addr, 32'd0);
    check("midrst req_ready", {31'd0, req_ready}, 32'd0);
    check("midrst resp_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1 check("midrst ready_low", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("midrst ready_high", {31'd0, req_ready}, 32'd1);
    apply_and_check(mk(1'b0, 3'b010, 32'h84, 32'h0, 1, 32'hCAFEF00D, 2'd0, 32'hCAFEF00D,
                       4'b1111, 32'h0, 2, 3), "after_rst_lw");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
